// File: rtl/maxnet_iterator.sv
// -----------------------------------------------------------------------------
// maxnet_iterator
//
// Four-neuron Maxnet competition engine. On start it latches four activations
// (negative values clamped to zero) and an inhibition weight, then alternates
// CHECK and UPDATE cycles until at most one neuron is still positive or the
// iteration cap is reached. The winner index drives the downstream 4-to-1
// selector's sel input.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        begin a competition (sampled only in IDLE)
//   din_a..din_d initial activations, signed fixed point (FRAC fraction bits)
//   eps          inhibition weight in [0, 1), same format as activations
//   busy         high in every non-IDLE state
//   done         one-cycle pulse in DONE
//   winner_idx   lowest index with a positive activation (0 if none)
//   winner_val   final activation of neuron winner_idx
//   unique_win   exactly one neuron was positive at termination
//                ("unique" itself is a reserved word, hence the suffix)
//   iter_count   number of UPDATE cycles executed
// -----------------------------------------------------------------------------
module maxnet_iterator #(
   parameter int XLEN     = 32,
   parameter int FRAC     = 16,
   parameter int MAX_ITER = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [XLEN-1:0] din_a,
   input  logic [XLEN-1:0] din_b,
   input  logic [XLEN-1:0] din_c,
   input  logic [XLEN-1:0] din_d,
   input  logic [XLEN-1:0] eps,
   output logic            busy,
   output logic            done,
   output logic [1:0]      winner_idx,
   output logic [XLEN-1:0] winner_val,
   output logic            unique_win,
   output logic [7:0]      iter_count
);

   // Sum of four non-negative XLEN values needs two extra bits; the product
   // of eps with that sum is kept at full width before the fixed-point shift.
   localparam int SW = XLEN + 2;
   localparam int PW = XLEN + SW;

   typedef enum logic [1:0] {IDLE, CHECK, UPDATE, DONE} state_t;

   state_t state, state_next;

   logic signed [XLEN-1:0] act      [4];
   logic signed [XLEN-1:0] act_next [4];
   logic signed [PW-1:0]   upd      [4];
   logic signed [XLEN-1:0] eps_r;
   logic [7:0]             iter;

   logic signed [SW-1:0]   sum;
   logic [2:0]             nz;
   logic [1:0]             win_idx;
   logic                   found;
   logic                   finish;

   function automatic logic signed [XLEN-1:0] relu(input logic [XLEN-1:0] x);
      return x[XLEN-1] ? '0 : signed'(x);
   endfunction

   // ---------------------------------------------------------------------------
   // Datapath: neuron count, winner priority and the next activations
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise a path that skips it would infer a latch.
      sum     = '0;
      nz      = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sum = sum + SW'(act[i]);
         if (act[i] > 0) begin
            nz = nz + 3'd1;
            if (!found) begin
               win_idx = 2'(i);
               found   = 1'b1;
            end
         end
      end
      // All four penalties use the same pre-update sum, so the neurons update
      // simultaneously. A negative result clamps to zero; otherwise the value
      // never exceeds the old activation and truncation to XLEN is lossless.
      for (int i = 0; i < 4; i++) begin
         upd[i]      = PW'(act[i])
                     - ((PW'(eps_r) * PW'(sum - SW'(act[i]))) >>> FRAC);
         act_next[i] = (upd[i] < 0) ? '0 : upd[i][XLEN-1:0];
      end
      finish = (nz <= 3'd1) || (iter == 8'(MAX_ITER));
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: registers take non-blocking assignments so every flop samples the
      // pre-edge value of every other flop, regardless of statement order.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CHECK;
         CHECK:   state_next = finish ? DONE : UPDATE;
         UPDATE:  state_next = CHECK;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // ---------------------------------------------------------------------------
   // Activations, iteration counter and registered results
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the activation array is only four words, so it is cleared with
         // the rest of the state; large memories are normally left unreset.
         act        <= '{default: '0};
         eps_r      <= '0;
         iter       <= '0;
         winner_idx <= '0;
         winner_val <= '0;
         unique_win <= 1'b0;
         iter_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  act[0] <= relu(din_a);
                  act[1] <= relu(din_b);
                  act[2] <= relu(din_c);
                  act[3] <= relu(din_d);
                  eps_r  <= signed'(eps);
                  iter   <= '0;
               end
            end
            CHECK: begin
               if (finish) begin
                  winner_idx <= win_idx;
                  winner_val <= act[win_idx];
                  unique_win <= (nz == 3'd1);
                  iter_count <= iter;
               end
            end
            UPDATE: begin
               act  <= act_next;
               iter <= iter + 8'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
